// File: rtl/inst_fetch_unit_pkg.sv
// Shared RISC-V core definitions used by the instruction-fetch slice:
// datapath widths, default reset PC, fetch FSM states and the buffered
// fetch entry layout.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } ifetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } ifetch_entry_t;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Fetch-unit bus: redirect input, instruction-memory request/response
// channel and the decode-side valid/ready channel.
// master = fetch unit, slave = surrounding core / memory / bench.
interface inst_fetch_unit_if;
  import riscv_pkg::*;

  logic            redirect;
  logic [XLEN-1:0] redirect_pc;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;

  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_pc_plus4;
  logic [ILEN-1:0] if_inst;
  logic            if_misaligned;

  modport master (
    input  redirect, redirect_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  if_ready,
    output imem_req_valid, imem_req_addr,
    output if_valid, if_pc, if_pc_plus4, if_inst, if_misaligned
  );

  modport slave (
    output redirect, redirect_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output if_ready,
    input  imem_req_valid, imem_req_addr,
    input  if_valid, if_pc, if_pc_plus4, if_inst, if_misaligned
  );

endinterface

// File: rtl/inst_fetch_unit_fifo.sv
// ifetch_fifo: synchronous instruction buffer with push, pop and flush.
// Flush has priority over push/pop. Push while full is accepted only when
// a pop happens in the same cycle. DEPTH must be a power of two.
module ifetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = XLEN + ILEN
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || pop);
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; contents are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: fetch PC, credit-limited imem requests, stale-response
// dropping after redirects and a decode-side instruction buffer.
// Optional feature macro: IFETCH_MISALIGN_TRAP_EN (halt on misaligned
// redirect target); when undefined, redirect_pc[1:0] is forced to zero.
module inst_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned     FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  inst_fetch_unit_if.master  bus
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  ifetch_state_t   state;
  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   out_next;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     credit_sum;
  logic [XLEN-1:0] target_pc;
  logic            req_fire;
  logic            rsp_keep;
  logic            fifo_flush;
  logic            fifo_empty;
  ifetch_entry_t   wr_entry;
  ifetch_entry_t   rd_entry;

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic [XLEN-1:0] halt_pc;
  logic            misaligned_tgt;
  assign target_pc      = bus.redirect_pc;
  assign misaligned_tgt = (bus.redirect_pc[1:0] != 2'b00);
`else
  assign target_pc      = {bus.redirect_pc[XLEN-1:2], 2'b00};
`endif

  assign credit_sum         = {1'b0, outstanding} + {1'b0, fifo_count};
  assign bus.imem_req_valid = (state == RUN) && (credit_sum < (CW+1)'(FIFO_DEPTH));
  assign bus.imem_req_addr  = fetch_pc;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;
  assign out_next           = outstanding + CW'(req_fire) - CW'(bus.imem_rsp_valid);

  // Responses are in order, so the oldest in-flight PC is fetch_pc - 4*outstanding.
  assign rsp_keep      = bus.imem_rsp_valid && (drop_cnt == '0) && !bus.redirect;
  assign wr_entry.pc   = fetch_pc - (XLEN'(outstanding) << 2);
  assign wr_entry.inst = bus.imem_rsp_data;
  assign fifo_flush    = bus.redirect || (state == HALT);

  ifetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (XLEN + ILEN)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rsp_keep),
    .pop   (bus.if_ready),
    .flush (fifo_flush),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Fetch FSM with PC, in-flight and stale-drop counters; redirect wins over request advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
`ifdef IFETCH_MISALIGN_TRAP_EN
      halt_pc     <= '0;
`endif
    end else begin
      outstanding <= out_next;
      if (state == IDLE) state <= RUN;
      if (req_fire) fetch_pc <= fetch_pc + 32'd4;
      if (bus.imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
      if (bus.redirect) begin
        fetch_pc <= target_pc;
        drop_cnt <= out_next;
`ifdef IFETCH_MISALIGN_TRAP_EN
        if (misaligned_tgt) begin
          state   <= HALT;
          halt_pc <= bus.redirect_pc;
        end else begin
          state   <= RUN;
        end
`endif
      end
    end
  end

  // Decode-side view of the buffer head; zeroed when nothing is valid.
  always_comb begin
    bus.if_valid      = !fifo_empty;
    bus.if_pc         = '0;
    bus.if_pc_plus4   = '0;
    bus.if_inst       = '0;
    bus.if_misaligned = 1'b0;
    if (!fifo_empty) begin
      bus.if_pc       = rd_entry.pc;
      bus.if_pc_plus4 = rd_entry.pc + 32'd4;
      bus.if_inst     = rd_entry.inst;
    end
`ifdef IFETCH_MISALIGN_TRAP_EN
    if (state == HALT) begin
      bus.if_pc         = halt_pc;
      bus.if_pc_plus4   = halt_pc + 32'd4;
      bus.if_misaligned = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: a vector table for streaming,
// back-pressure and redirect cases, then hand-written sequences for the
// misaligned target (IFETCH_MISALIGN_TRAP_EN aware) and mid-stream reset.
// The memory model returns addr + 0x1000_0000 one cycle after acceptance.
module tb_inst_fetch_unit;

  logic clk;
  logic rst_n;

  inst_fetch_unit_if bus();

  inst_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        redirect;
    logic [31:0] rpc;
    logic        req_ready;
    logic        if_ready;
    logic        hold;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_ifv;
    logic [31:0] e_pc;
  } vec_t;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] mq[$];
  logic        mem_hold = 1'b0;
  vec_t        tbl[27];

  function automatic vec_t mk(input logic rd, input logic [31:0] rpc, input logic rdy,
                              input logic ifr, input logic hold, input logic rv,
                              input logic [31:0] addr, input logic ifv, input logic [31:0] pc);
    vec_t v;
    v.redirect = rd;  v.rpc = rpc;   v.req_ready = rdy; v.if_ready = ifr; v.hold = hold;
    v.e_rv = rv;      v.e_addr = addr; v.e_ifv = ifv;   v.e_pc = pc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  // One clock: sample handshakes mid-cycle, then advance the memory model.
  task automatic cycle();
    logic        fire;
    logic        rsp;
    logic [31:0] addr;
    @(negedge clk);
    fire = bus.imem_req_valid && bus.imem_req_ready;
    addr = bus.imem_req_addr;
    rsp  = bus.imem_rsp_valid;
    @(posedge clk);
    #1;
    if (rsp && mq.size() != 0) void'(mq.pop_front());
    if (fire) mq.push_back(addr);
    bus.imem_rsp_valid = (mq.size() != 0) && !mem_hold;
    bus.imem_rsp_data  = (mq.size() != 0) ? mq[0] + 32'h1000_0000 : 32'h0;
  endtask

  task automatic wait_ifv(input string nm, input logic [31:0] exp_pc);
    int unsigned n = 0;
    while (!bus.if_valid && n < 12) begin
      cycle();
      n++;
    end
    chk({nm, "_valid"}, 32'(bus.if_valid), 32'd1);
    chk({nm, "_pc"},    bus.if_pc, exp_pc);
    chk({nm, "_inst"},  bus.if_inst, exp_pc + 32'h1000_0000);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_req_valid"}, 32'(bus.imem_req_valid), 32'd0);
    chk({nm, "_req_addr"},  bus.imem_req_addr, 32'h0);
    chk({nm, "_if_valid"},  32'(bus.if_valid), 32'd0);
    chk({nm, "_if_pc"},     bus.if_pc, 32'h0);
    chk({nm, "_if_pc4"},    bus.if_pc_plus4, 32'h0);
    chk({nm, "_if_inst"},   bus.if_inst, 32'h0);
    chk({nm, "_misalign"},  32'(bus.if_misaligned), 32'd0);
  endtask

  initial begin
    logic [31:0] resume_pc;

    rst_n              = 1'b0;
    bus.redirect       = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.if_ready       = 1'b1;

    //            rd  rpc    rdy ifr hld | rv addr   ifv pc
    tbl[0]  = mk(0, 32'h0,   1, 1, 0,   0, 32'h000, 0, 32'h000);
    tbl[1]  = mk(0, 32'h0,   1, 1, 0,   1, 32'h000, 0, 32'h000);
    tbl[2]  = mk(0, 32'h0,   1, 1, 0,   1, 32'h004, 0, 32'h000);
    tbl[3]  = mk(0, 32'h0,   1, 1, 0,   1, 32'h008, 1, 32'h000);
    tbl[4]  = mk(0, 32'h0,   1, 1, 0,   1, 32'h00C, 1, 32'h004);
    tbl[5]  = mk(0, 32'h0,   1, 0, 0,   1, 32'h010, 1, 32'h008);
    tbl[6]  = mk(0, 32'h0,   1, 0, 0,   1, 32'h014, 1, 32'h008);
    tbl[7]  = mk(0, 32'h0,   1, 0, 0,   0, 32'h018, 1, 32'h008);
    tbl[8]  = mk(0, 32'h0,   1, 0, 0,   0, 32'h018, 1, 32'h008);
    tbl[9]  = mk(0, 32'h0,   1, 1, 0,   0, 32'h018, 1, 32'h008);
    tbl[10] = mk(0, 32'h0,   1, 0, 0,   1, 32'h018, 1, 32'h00C);
    tbl[11] = mk(0, 32'h0,   1, 0, 0,   0, 32'h01C, 1, 32'h00C);
    tbl[12] = mk(0, 32'h0,   1, 0, 0,   0, 32'h01C, 1, 32'h00C);
    tbl[13] = mk(0, 32'h0,   1, 1, 1,   0, 32'h01C, 1, 32'h00C);
    tbl[14] = mk(0, 32'h0,   1, 1, 1,   1, 32'h01C, 1, 32'h010);
    tbl[15] = mk(0, 32'h0,   1, 1, 1,   1, 32'h020, 1, 32'h014);
    tbl[16] = mk(1, 32'h100, 0, 1, 0,   1, 32'h024, 1, 32'h018);
    tbl[17] = mk(0, 32'h0,   1, 1, 0,   1, 32'h100, 0, 32'h000);
    tbl[18] = mk(0, 32'h0,   1, 1, 0,   1, 32'h104, 0, 32'h000);
    tbl[19] = mk(0, 32'h0,   1, 1, 0,   1, 32'h108, 0, 32'h000);
    tbl[20] = mk(0, 32'h0,   1, 1, 0,   1, 32'h10C, 1, 32'h100);
    tbl[21] = mk(1, 32'h200, 1, 1, 0,   1, 32'h110, 1, 32'h104);
    tbl[22] = mk(0, 32'h0,   1, 1, 0,   1, 32'h200, 0, 32'h000);
    tbl[23] = mk(0, 32'h0,   1, 1, 0,   1, 32'h204, 0, 32'h000);
    tbl[24] = mk(0, 32'h0,   1, 1, 0,   1, 32'h208, 0, 32'h000);
    tbl[25] = mk(0, 32'h0,   1, 1, 0,   1, 32'h20C, 1, 32'h200);
    tbl[26] = mk(0, 32'h0,   1, 1, 0,   1, 32'h210, 1, 32'h204);

    #12;
    chk_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 27; i++) begin
      bus.redirect       = tbl[i].redirect;
      bus.redirect_pc    = tbl[i].rpc;
      bus.imem_req_ready = tbl[i].req_ready;
      bus.if_ready       = tbl[i].if_ready;
      mem_hold           = tbl[i].hold;
      #1;
      chk($sformatf("v%0d_req_valid", i), 32'(bus.imem_req_valid), 32'(tbl[i].e_rv));
      chk($sformatf("v%0d_req_addr", i),  bus.imem_req_addr, tbl[i].e_addr);
      chk($sformatf("v%0d_if_valid", i),  32'(bus.if_valid), 32'(tbl[i].e_ifv));
      chk($sformatf("v%0d_if_pc", i),     bus.if_pc, tbl[i].e_pc);
      chk($sformatf("v%0d_if_pc4", i),    bus.if_pc_plus4,
          tbl[i].e_ifv ? tbl[i].e_pc + 32'd4 : 32'h0);
      chk($sformatf("v%0d_if_inst", i),   bus.if_inst,
          tbl[i].e_ifv ? tbl[i].e_pc + 32'h1000_0000 : 32'h0);
      cycle();
    end
    bus.redirect = 1'b0;
    mem_hold     = 1'b0;

`ifdef IFETCH_MISALIGN_TRAP_EN
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h102;
    bus.if_ready    = 1'b1;
    cycle();
    bus.redirect = 1'b0;
    chk("halt_misaligned", 32'(bus.if_misaligned), 32'd1);
    chk("halt_if_pc",      bus.if_pc, 32'h102);
    chk("halt_if_valid",   32'(bus.if_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("halt%0d_req_valid", k), 32'(bus.imem_req_valid), 32'd0);
      chk($sformatf("halt%0d_if_valid", k),  32'(bus.if_valid), 32'd0);
      cycle();
    end
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h200;
    cycle();
    bus.redirect = 1'b0;
    bus.if_ready = 1'b0;
    chk("resume_misaligned", 32'(bus.if_misaligned), 32'd0);
    chk("resume_req_valid",  32'(bus.imem_req_valid), 32'd1);
    chk("resume_req_addr",   bus.imem_req_addr, 32'h200);
    resume_pc = 32'h200;
`else
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h302;
    bus.if_ready    = 1'b1;
    cycle();
    bus.redirect = 1'b0;
    bus.if_ready = 1'b0;
    chk("align_misaligned", 32'(bus.if_misaligned), 32'd0);
    chk("align_req_valid",  32'(bus.imem_req_valid), 32'd1);
    chk("align_req_addr",   bus.imem_req_addr, 32'h300);
    chk("align_if_valid",   32'(bus.if_valid), 32'd0);
    resume_pc = 32'h300;
`endif
    wait_ifv("resume", resume_pc);
    cycle();
    cycle();
    chk("prereset_if_valid", 32'(bus.if_valid), 32'd1);
    chk("prereset_if_pc",    bus.if_pc, resume_pc);

    #2;
    rst_n = 1'b0;
    mq.delete();
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    #1;
    chk_reset_outputs("midreset");
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    bus.if_ready = 1'b1;
    #1;
    chk("rel_idle_req_valid", 32'(bus.imem_req_valid), 32'd0);
    cycle();
    chk("rel_first_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("rel_first_req_addr",  bus.imem_req_addr, 32'h0);
    wait_ifv("rel", 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "simulation time limit");
  end

endmodule
